// File: rtl/sub_add_pkg.sv
// Shared definitions for the serial sub/add unit:
// FSM encoding, mode constants and counter sizing.
package sub_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // ceil(log2(n)), never less than one bit
    function automatic int cnt_width(input int n);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/digit_sub_add.sv
// One DIGIT-wide slice of the add/subtract ripple chain.
// chain is carry when adding and borrow when subtracting.
module digit_sub_add
    import sub_add_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             chain_in,
    input  logic             sub_add,
    output logic [DIGIT-1:0] dif_sum,
    output logic             chain_out
);

    logic [DIGIT:0] c;

    // Per-bit full adder / full subtractor ripple
    always_comb begin
        c       = '0;
        dif_sum = '0;
        c[0]    = chain_in;
        for (int i = 0; i < DIGIT; i++) begin
            dif_sum[i] = x[i] ^ y[i] ^ c[i];
            if (sub_add == MODE_SUB)
                c[i+1] = (~x[i] & y[i]) | (y[i] & c[i]) | (~x[i] & c[i]);
            else
                c[i+1] = (x[i] & y[i]) | (y[i] & c[i]) | (x[i] & c[i]);
        end
        chain_out = c[DIGIT];
    end

endmodule

// File: rtl/serial_sub_add_unit.sv
// Multi-cycle adder/subtractor, DIGIT bits per clock, LSB digit first.
// Results and flags update together on the completing edge only.
module serial_sub_add_unit
    import sub_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_CIN,
    input  logic             SUB_ADD,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D_S,
    output logic             B_COUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] res;
    logic             mode_q;
    logic             chain_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] x_d;
    logic [DIGIT-1:0] y_d;
    logic [DIGIT-1:0] ds;
    logic             chain_out;
    logic             accept;
    logic             last;
    logic             ovf_d;

    digit_sub_add #(.DIGIT(DIGIT)) u_digit (
        .x        (x_d),
        .y        (y_d),
        .chain_in (chain_q),
        .sub_add  (mode_q),
        .dif_sum  (ds),
        .chain_out(chain_out)
    );

    // Pick the operand digit addressed by the counter
    always_comb begin
        x_d = '0;
        y_d = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                x_d = a_q[i*DIGIT +: DIGIT];
                y_d = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    // Next state: accept START only in IDLE, leave RUN on the last digit
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full result with the final digit merged in, plus signed overflow
    always_comb begin
        res = shadow_q;
        res[(N-1)*DIGIT +: DIGIT] = ds;
        if (mode_q == MODE_ADD)
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (res[WIDTH-1] != a_q[WIDTH-1]);
        else
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (res[WIDTH-1] != a_q[WIDTH-1]);
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand capture and digit-serial datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            chain_q  <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            mode_q  <= SUB_ADD;
            chain_q <= B_CIN;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            chain_q <= chain_out;
            cnt_q   <= last ? '0 : cnt_q + CW'(1);
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CW'(i))
                    shadow_q[i*DIGIT +: DIGIT] <= ds;
            end
        end
    end

    // Visible result registers, updated only on completion
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DONE   <= 1'b0;
            D_S    <= '0;
            B_COUT <= 1'b0;
            OVF    <= 1'b0;
            ZERO   <= 1'b0;
        end else begin
            DONE <= last;
            if (last) begin
                D_S    <= res;
                B_COUT <= chain_out;
                OVF    <= ovf_d;
                ZERO   <= ~|res;
            end
        end
    end

    assign BUSY = (state_q == RUN);

endmodule

// File: doc/serial_sub_add_unit.md
# serial_sub_add_unit

Parametrised, multi-cycle adder/subtractor that processes a `WIDTH`-bit operand pair `DIGIT` bits per clock. It uses a START/BUSY/DONE handshake and produces registered result and status flags. It is the next generation of the team's 4/8-bit ripple sub/add datapath: it keeps the same borrow/carry semantics on `B_CIN`/`B_COUT` and adds width generality, area/latency trade-off, and overflow/zero flags. It sits between a controller that issues operations and a result consumer that samples on DONE.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: request an operation; sampled only in IDLE.
- `A` in WIDTH: minuend/augend; captured on accepted START.
- `B` in WIDTH: subtrahend/addend; captured on accepted START.
- `B_CIN` in 1: carry-in (add) or borrow-in (subtract); captured on START.
- `SUB_ADD` in 1: 0 = add, 1 = subtract; captured on START.
- `BUSY` out 1: high while an operation is in progress.
- `DONE` out 1: one-cycle pulse when the result registers update.
- `D_S` out WIDTH: sum or difference.
- `B_COUT` out 1: carry-out (add) or borrow-out (subtract).
- `OVF` out 1: two's-complement signed overflow.
- `ZERO` out 1: `D_S` == 0.

## Operation
- Let N = `WIDTH`/`DIGIT`.
- Add: {`B_COUT`,`D_S`} = `A` + `B` + `B_CIN`.
- Subtract: `D_S` = (`A` − `B` − `B_CIN`) mod 2^WIDTH. `B_COUT` = 1 iff `A` < `B` + `B_CIN` (unsigned).
- `OVF`, add: sign(A) == sign(B) and sign(D_S) ≠ sign(A).
- `OVF`, subtract: sign(A) ≠ sign(B) and sign(D_S) ≠ sign(A).
- FSM states:
  - IDLE: START=1 → RUN. Capture operands and mode, digit counter = 0, internal chain bit = `B_CIN`.
  - RUN: each cycle, combine digit [counter] of the captured operands with the chain bit. Store the partial result digit, update the chain bit, increment the counter.
  - RUN → IDLE on the cycle that processes digit N−1.
- Digit order: LSB digit first.
- The result shadow register fills digit by digit. `D_S`, `B_COUT`, `OVF` and `ZERO` update together, only on the completing edge. They hold until the next completion.
- START while BUSY is ignored. It is neither queued nor allowed to disturb the captured operands.
- Input changes on `A`/`B`/`B_CIN`/`SUB_ADD` after capture have no effect.
- Reset mid-operation aborts the operation: no DONE, and the outputs return to reset values.

## Timing
- Reset values: state IDLE, `BUSY`=0, `DONE`=0, `D_S`=0, `B_COUT`=0, `OVF`=0, `ZERO`=0, counter 0.
- START accepted at edge k.
- `BUSY` is high from after edge k to after edge k+N.
- `DONE` and the result are valid in the cycle after edge k+N, so latency is N cycles.
- `DONE` is high for exactly one cycle. `BUSY` is 0 in that cycle.
- START held high in the DONE cycle is accepted (state is IDLE). Back-to-back period is N+1 cycles.
- `DIGIT`=`WIDTH` (N=1) is legal: a single RUN cycle with latency 1.
- `DIGIT`=1 gives bit-serial operation with latency `WIDTH`.

## Structure
- Shared package `sub_add_pkg` holds:
  - the state encoding (IDLE=0, RUN=1),
  - the mode constants (`MODE_ADD`=0, `MODE_SUB`=1),
  - the counter-width function ceil(log2(N)), minimum 1.
- One combinational sub-module, `digit_sub_add`, parametrised by `DIGIT`:
  - inputs: x[DIGIT], y[DIGIT], chain-in, sub_add;
  - outputs: dif_sum[DIGIT], chain-out;
  - built as a per-bit full add/subtract ripple using borrow = (~x&y)|(y&bin)|(~x&bin).
- `OVF` is computed from captured sign bits and the final MSB, not from the chain bits.

## Test plan
- WIDTH=16, DIGIT=4, add 0x7FFF+0x0001, cin 0 → `D_S`=0x8000, `B_COUT`=0, `OVF`=1, `ZERO`=0. `DONE` 4 cycles after START.
- Add 0xFFFF+0x0000, cin 1 → `D_S`=0x0000, `B_COUT`=1, `OVF`=0, `ZERO`=1.
- Subtract 0x0000−0x0001, bin 0 → `D_S`=0xFFFF, `B_COUT`=1, `OVF`=0. Subtract 0x8000−0x0001 → `D_S`=0x7FFF, `B_COUT`=0, `OVF`=1.
- START pulsed on cycles 2 and 3 of a running operation with different operands → only the first result appears. One `DONE`, and the next START in the `DONE` cycle is accepted.
- `RST_N` low during cycle 2 of RUN → `BUSY`=0 and all outputs 0 immediately. No `DONE`. The next operation completes normally.
- Parameter sweep {DIGIT=1, 4, 16} with 1000 random operands per mode → results match a reference model, and latency equals `WIDTH`/`DIGIT`.
